// File: rtl/mcu_subsys_mem_arbiter_if.sv
// Memory handshake bundle (valid/ready/addr/wdata/wstrb/rdata) shared by the
// CPU port, the GNSS DMA port and the SRAM port of the arbiter.
interface mcu_subsys_mem_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;   // 0 means read
    logic [31:0]       mem_rdata;

    // Requester side: issues the access, receives completion and read data.
    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_ready,
        input  mem_rdata
    );

    // Responder side: accepts the access, returns completion and read data.
    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mcu_subsys_mem_arbiter.sv
// Two-master / one-slave arbiter for the MCU subsystem single-port SRAM.
// Master 0 is the CPU, master 1 the GNSS capture DMA. Round-robin between
// contending masters, grant locked until completion, and a slave-response
// timeout that forces completion with ERR_RDATA and suppresses the access.
module mcu_subsys_mem_arbiter #(
    parameter int          ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                            clk,
    input  logic                            rst,
    mcu_subsys_mem_arbiter_if.slave         m0,
    mcu_subsys_mem_arbiter_if.slave         m1,
    mcu_subsys_mem_arbiter_if.master        s,
    output logic [1:0]                      grant,
    output logic                            timeout_pulse,
    output logic [7:0]                      timeout_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Counter only has to reach TIMEOUT_CYCLES-1 before the forced exit.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    state_t            state;
    state_t            state_next;
    logic              prefer_m1;     // round-robin pointer: 1 -> master 1 wins a tie
    logic [CNT_W-1:0]  to_cnt;        // not-ready cycles in the current grant

    // Owner-selected request (zero while idle, which also zeroes the SRAM bus).
    logic              own_valid;
    logic [ADDR_W-1:0] own_addr;
    logic [31:0]       own_wdata;
    logic [3:0]        own_wstrb;

    logic              timeout_hit;
    logic              complete;
    logic              resp_ready;
    logic [31:0]       resp_rdata;

    // Select the granted master's request signals.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        own_valid = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        own_wstrb = '0;
        case (state)
            GNT0: begin
                own_valid = m0.mem_valid;
                own_addr  = m0.mem_addr;
                own_wdata = m0.mem_wdata;
                own_wstrb = m0.mem_wstrb;
            end
            GNT1: begin
                own_valid = m1.mem_valid;
                own_addr  = m1.mem_addr;
                own_wdata = m1.mem_wdata;
                own_wstrb = m1.mem_wstrb;
            end
            default: ;
        endcase
    end

    // A real slave ready always beats the timeout in the same cycle.
    assign timeout_hit = TO_EN && own_valid && !s.mem_ready && (to_cnt == TO_LAST);
    assign complete    = own_valid && (s.mem_ready || timeout_hit);
    assign resp_ready  = complete;
    assign resp_rdata  = timeout_hit ? ERR_RDATA : s.mem_rdata;

    // Slave side: pass the owner's request through, but withhold it on a
    // forced completion so a timed-out write never lands.
    assign s.mem_valid = own_valid && !timeout_hit;
    assign s.mem_addr  = own_addr;
    assign s.mem_wdata = own_wdata;
    assign s.mem_wstrb = own_wstrb;

    // Master side: only the owner sees completion and read data.
    assign m0.mem_ready = (state == GNT0) && resp_ready;
    assign m0.mem_rdata = (state == GNT0) ? resp_rdata : 32'h0;
    assign m1.mem_ready = (state == GNT1) && resp_ready;
    assign m1.mem_rdata = (state == GNT1) ? resp_rdata : 32'h0;

    assign grant         = {state == GNT1, state == GNT0};
    assign timeout_pulse = timeout_hit;

    // Next-state: arbitrate from IDLE, hold the grant until completion or abandon.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (m0.mem_valid && m1.mem_valid) begin
                    state_next = prefer_m1 ? GNT1 : GNT0;
                end else if (m0.mem_valid) begin
                    state_next = GNT0;
                end else if (m1.mem_valid) begin
                    state_next = GNT1;
                end
            end
            GNT0, GNT1: begin
                // Dropped valid (abandon) or completion both return to IDLE.
                if (!own_valid || complete) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, pointer, timeout counter and saturating timeout statistics.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            prefer_m1     <= 1'b0;
            to_cnt        <= '0;
            timeout_count <= 8'd0;
        end else begin
            state <= state_next;

            // Cleared while idle, so every grant starts counting from zero.
            if (state == IDLE) begin
                to_cnt <= '0;
            end else if (!s.mem_ready) begin
                to_cnt <= to_cnt + 1'b1;
            end

            // Any completion (normal or forced) hands preference to the other master;
            // an abandoned request leaves the pointer alone.
            if (complete) begin
                prefer_m1 <= (state == GNT0);
            end

            if (timeout_hit && (timeout_count != 8'hFF)) begin
                timeout_count <= timeout_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mcu_subsys_mem_arbiter.sv
// Scoreboard bench for mcu_subsys_mem_arbiter: stimulus tasks push expected
// master responses and slave accesses; a negedge monitor pops and compares.
module tb_mcu_subsys_mem_arbiter;

    typedef struct {
        logic [31:0] rdata;
        bit          timeout;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } slv_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  grant;
    logic        timeout_pulse;
    logic [7:0]  timeout_count;

    logic        sl_ready = 1'b1;
    logic [31:0] sl_rdata = 32'h0;

    int checks = 0;
    int errors = 0;
    int s_valid_cycles = 0;

    resp_t exp_q0[$];
    resp_t exp_q1[$];
    slv_t  slv_q0[$];
    slv_t  slv_q1[$];
    int    done_order[$];
    logic [1:0] grant_log[$];

    mcu_subsys_mem_arbiter_if #(.ADDR_W(32)) m0_if ();
    mcu_subsys_mem_arbiter_if #(.ADDR_W(32)) m1_if ();
    mcu_subsys_mem_arbiter_if #(.ADDR_W(32)) s_if ();

    assign s_if.mem_ready = sl_ready;
    assign s_if.mem_rdata = sl_rdata;

    mcu_subsys_mem_arbiter #(
        .ADDR_W        (32),
        .TIMEOUT_CYCLES(16),
        .ERR_RDATA     (32'hDEAD_BEEF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m0           (m0_if),
        .m1           (m1_if),
        .s            (s_if),
        .grant        (grant),
        .timeout_pulse(timeout_pulse),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every master completion and every slave access.
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_if.mem_ready) begin
                if (exp_q0.size() == 0) begin
                    check("m0_unexpected_ready", 32'(m0_if.mem_ready), 32'h0);
                end else begin
                    resp_t e;
                    e = exp_q0.pop_front();
                    check("m0_rdata", m0_if.mem_rdata, e.rdata);
                    check("m0_timeout_pulse", 32'(timeout_pulse), 32'(e.timeout));
                    done_order.push_back(0);
                end
            end
            if (m1_if.mem_ready) begin
                if (exp_q1.size() == 0) begin
                    check("m1_unexpected_ready", 32'(m1_if.mem_ready), 32'h0);
                end else begin
                    resp_t e;
                    e = exp_q1.pop_front();
                    check("m1_rdata", m1_if.mem_rdata, e.rdata);
                    check("m1_timeout_pulse", 32'(timeout_pulse), 32'(e.timeout));
                    done_order.push_back(1);
                end
            end
            if (timeout_pulse && !m0_if.mem_ready && !m1_if.mem_ready) begin
                check("stray_timeout_pulse", 32'(timeout_pulse), 32'h0);
            end
            if (s_if.mem_valid) s_valid_cycles++;
            if (s_if.mem_valid && s_if.mem_ready) begin
                slv_t e;
                bit   have;
                have = 1'b0;
                if (grant == 2'b01 && slv_q0.size() != 0) begin
                    e = slv_q0.pop_front();
                    have = 1'b1;
                end else if (grant == 2'b10 && slv_q1.size() != 0) begin
                    e = slv_q1.pop_front();
                    have = 1'b1;
                end
                if (!have) begin
                    check("slave_unexpected_access", 32'(s_if.mem_valid), 32'h0);
                end else begin
                    check("s_addr", s_if.mem_addr, e.addr);
                    check("s_wdata", s_if.mem_wdata, e.wdata);
                    check("s_wstrb", 32'(s_if.mem_wstrb), 32'(e.wstrb));
                end
            end
        end
    end

    task automatic drive(input int n, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] w);
        if (n == 0) begin
            m0_if.mem_valid = v; m0_if.mem_addr = a; m0_if.mem_wdata = d; m0_if.mem_wstrb = w;
        end else begin
            m1_if.mem_valid = v; m1_if.mem_addr = a; m1_if.mem_wdata = d; m1_if.mem_wstrb = w;
        end
    endtask

    // One transaction: push expectations, hold valid until ready, then release.
    // lat counts negedges from raising valid up to and including the ready cycle.
    task automatic txn(input int n, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] w, input bit exp_to, output int lat);
        resp_t r;
        slv_t  sx;
        bit    seen;
        r.rdata   = exp_to ? 32'hDEAD_BEEF : sl_rdata;
        r.timeout = exp_to;
        sx.addr = a; sx.wdata = d; sx.wstrb = w;
        if (n == 0) exp_q0.push_back(r); else exp_q1.push_back(r);
        if (!exp_to) begin
            if (n == 0) slv_q0.push_back(sx); else slv_q1.push_back(sx);
        end
        drive(n, 1'b1, a, d, w);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 200) begin
            @(negedge clk);
            lat++;
            seen = (n == 0) ? m0_if.mem_ready : m1_if.mem_ready;
        end
        if (!seen) check("txn_ready_bound", 32'(seen), 32'h1);
        @(posedge clk);
        #1;
        drive(n, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic master_burst(input int n, input logic [31:0] base);
        int lat;
        for (int i = 0; i < 4; i++) begin
            txn(n, base + 32'(i * 4), base ^ 32'(i), 4'hF, 1'b0, lat);
        end
    endtask

    initial begin
        int lat;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state; idle SRAM bus stays zero even with master inputs non-zero.
        drive(0, 1'b0, 32'h1234, 32'h5555_AAAA, 4'hF);
        @(negedge clk);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_s_valid", 32'(s_if.mem_valid), 32'h0);
        check("rst_m0_ready", 32'(m0_if.mem_ready), 32'h0);
        check("rst_m1_ready", 32'(m1_if.mem_ready), 32'h0);
        check("rst_timeout_pulse", 32'(timeout_pulse), 32'h0);
        check("rst_timeout_count", 32'(timeout_count), 32'h0);
        check("idle_s_addr", s_if.mem_addr, 32'h0);
        check("idle_s_wdata", s_if.mem_wdata, 32'h0);
        check("idle_s_wstrb", 32'(s_if.mem_wstrb), 32'h0);
        @(posedge clk);
        #1;

        // 1. Single read with one cycle of arbitration latency.
        sl_ready = 1'b1;
        sl_rdata = 32'h1234_5678;
        fork
            txn(0, 32'h100, 32'h0, 4'h0, 1'b0, lat);
            begin
                @(negedge clk);
                check("t1_arb_s_valid", 32'(s_if.mem_valid), 32'h0);
                check("t1_arb_grant", 32'(grant), 32'h0);
                @(negedge clk);
                check("t1_s_valid", 32'(s_if.mem_valid), 32'h1);
                check("t1_grant", 32'(grant), 32'h1);
                check("t1_m0_ready", 32'(m0_if.mem_ready), 32'h1);
            end
        join
        check("t1_latency", 32'(lat), 32'd2);

        // 2. Continuous contention: strict alternation starting with master 0.
        do_reset();
        sl_rdata = 32'h0BAD_F00D;
        done_order.delete();
        grant_log.delete();
        fork
            master_burst(0, 32'h0000_1000);
            master_burst(1, 32'h0000_2000);
            for (int k = 0; k < 16; k++) begin
                @(negedge clk);
                grant_log.push_back(grant);
            end
        join
        for (int k = 0; k < 16; k++) begin
            logic [1:0] g;
            g = (k % 2 == 0) ? 2'b00 : ((((k - 1) / 2) % 2 == 0) ? 2'b01 : 2'b10);
            check($sformatf("t2_grant_%0d", k), 32'(grant_log[k]), 32'(g));
        end
        check("t2_completions", 32'(done_order.size()), 32'd8);
        for (int k = 0; k < done_order.size(); k++) begin
            check($sformatf("t2_order_%0d", k), 32'(done_order[k]), 32'(k % 2));
        end

        // 3. Single-byte write from master 1: exactly one SRAM cycle.
        s_valid_cycles = 0;
        txn(1, 32'h40, 32'hAABB_CCDD, 4'b0100, 1'b0, lat);
        check("t3_s_valid_cycles", 32'(s_valid_cycles), 32'd1);

        // 4. Timeout on the 16th grant cycle, then saturation of the counter.
        sl_ready = 1'b0;
        s_valid_cycles = 0;
        txn(0, 32'h200, 32'h0, 4'h0, 1'b1, lat);
        check("t4_latency", 32'(lat), 32'd17);
        check("t4_timeout_count", 32'(timeout_count), 32'd1);
        for (int k = 0; k < 300; k++) begin
            txn(0, 32'h200, 32'h0, 4'h0, 1'b1, lat);
        end
        check("t4_timeout_count_sat", 32'(timeout_count), 32'd255);

        // 5b. Reset in the middle of a GNT0 transaction.
        drive(0, 1'b1, 32'h300, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        check("t5_pre_rst_grant", 32'(grant), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("t5_rst_grant", 32'(grant), 32'h0);
        check("t5_rst_s_valid", 32'(s_if.mem_valid), 32'h0);
        check("t5_rst_m0_ready", 32'(m0_if.mem_ready), 32'h0);
        check("t5_rst_timeout_count", 32'(timeout_count), 32'h0);
        @(posedge clk);
        #1;

        // 6. Slave ready arrives on the exact cycle the timeout would fire.
        sl_rdata = 32'hCAFE_F00D;
        fork
            txn(0, 32'h400, 32'h0, 4'h0, 1'b0, lat);
            begin
                repeat (16) @(posedge clk);
                #1;
                sl_ready = 1'b1;
            end
        join
        check("t6_latency", 32'(lat), 32'd17);
        check("t6_timeout_count", 32'(timeout_count), 32'h0);

        // 5a. Abandon: master 1 drops valid mid-grant; pointer stays on master 0.
        do_reset();
        sl_ready = 1'b0;
        drive(1, 1'b1, 32'h80, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);
        check("t5_abandon_grant", 32'(grant), 32'h2);
        @(posedge clk);
        #1;
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        check("t5_abandon_m1_ready", 32'(m1_if.mem_ready), 32'h0);
        check("t5_abandon_s_valid", 32'(s_if.mem_valid), 32'h0);
        @(negedge clk);
        check("t5_abandon_idle", 32'(grant), 32'h0);
        @(posedge clk);
        #1;
        sl_ready = 1'b1;
        sl_rdata = 32'h0000_0A0A;
        fork
            txn(0, 32'h500, 32'h1, 4'hF, 1'b0, lat);
            txn(1, 32'h600, 32'h2, 4'hF, 1'b0, lat);
            begin
                @(negedge clk);
                @(negedge clk);
                check("t5_pointer_kept", 32'(grant), 32'h1);
            end
        join

        repeat (2) @(negedge clk);
        check("q_m0_empty", 32'(exp_q0.size()), 32'h0);
        check("q_m1_empty", 32'(exp_q1.size()), 32'h0);
        check("q_s0_empty", 32'(slv_q0.size()), 32'h0);
        check("q_s1_empty", 32'(slv_q1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
